// File: rtl/perf_snap_master.sv
// Wishbone block-copy initiator: moves count 32-bit words from src_base to dst_base, one read/write pair per word.
// Optional bus watchdog is compiled in when PERF_SNAP_TIMEOUT_EN is defined.
module perf_snap_master #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_adr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i
);

  localparam int unsigned AW = 32;

  // Word offsets are formed as {idx, 2'b00} inside a 32-bit address.
  if (CNT_W < 1 || CNT_W > 30 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("perf_snap_master: illegal CNT_W or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_RRTY, S_WRTY, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d, adr_d, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d, idx_inc;
  logic             cyc_d, stb_d, we_d, busy_d, done_d, error_d;
  logic             timeout, resp_err, resp_rty, resp_ack;

  assign wb_sel_o = 4'hF;
  assign idx_inc  = idx_q + CNT_W'(1);

  // Response decode with err (or watchdog) > rty > ack.
  assign resp_err = wb_stb_o & (wb_err_i | timeout);
  assign resp_rty = wb_stb_o & ~resp_err & wb_rty_i;
  assign resp_ack = wb_stb_o & ~resp_err & ~wb_rty_i & wb_ack_i;

`ifdef PERF_SNAP_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            stall;

  assign stall   = wb_stb_o & ~wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign timeout = stall & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive unanswered strobe cycles; any gap or response restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (stall && !timeout) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dat_d   = wb_dat_o;
    error_d = error;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          cnt_d   = count;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = (count == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        if (resp_err) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (resp_rty) begin
          state_d = S_RRTY;
        end else if (resp_ack) begin
          dat_d   = wb_dat_i;
          state_d = S_RGAP;
        end
      end
      S_WR: begin
        if (resp_err) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (resp_rty) begin
          state_d = S_WRTY;
        end else if (resp_ack) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == cnt_q) ? S_FIN : S_WGAP;
        end
      end
      S_RGAP:  state_d = S_WR;
      S_WGAP:  state_d = S_RD;
      S_RRTY:  state_d = S_RD;
      S_WRTY:  state_d = S_WR;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cyc_d  = state_d inside {S_RD, S_RGAP, S_WR, S_WGAP, S_RRTY, S_WRTY};
    stb_d  = state_d inside {S_RD, S_WR};
    we_d   = (state_d == S_WR);
    busy_d = cyc_d;
    done_d = (state_d == S_FIN);

    // Address is only reloaded for a strobed state, so it holds through gaps.
    adr_d = wb_adr_o;
    if (state_d == S_RD) begin
      adr_d = src_d + AW'({idx_d, 2'b00});
    end else if (state_d == S_WR) begin
      adr_d = dst_d + AW'({idx_d, 2'b00});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      wb_dat_o <= '0;
      wb_adr_o <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wb_dat_o <= dat_d;
      wb_adr_o <= adr_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= stb_d;
      wb_we_o  <= we_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

endmodule

// File: tb/tb_perf_snap_master.sv
// Directed bench for perf_snap_master: zero-wait Wishbone slave with one-shot retry/error injection.
module tb_perf_snap_master;

  localparam logic [31:0] RD_BASE = 32'h9900_0000;
  localparam logic [31:0] WR_BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_base = '0;
  logic [31:0] dst_base = '0;
  logic [7:0]  count = '0;
  logic        busy, done, error;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Slave controls and logs
  logic        mute = 1'b0;
  int          rty_at = 0;
  logic [31:0] err_adr = 32'hFFFF_FFFC;
  logic [31:0] att_adr [0:63];
  logic        att_we  [0:63];
  logic [31:0] wr_adr  [0:63];
  logic [31:0] wr_dat  [0:63];
  int att_n = 0, wr_n = 0, done_n = 0, busy_n = 0, stb_n = 0;
  logic err_done, cyc_done, busy_done;

  perf_snap_master #(.CNT_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_base(src_base), .dst_base(dst_base), .count(count),
    .busy(busy), .done(done), .error(error),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  // Zero-wait slave: answers in the same cycle the strobe is seen; also counts done/busy/stb cycles.
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = '0;
    if (done) done_n++;
    if (busy) busy_n++;
    if (wb_stb_o) stb_n++;
    if (wb_cyc_o && wb_stb_o && !mute) begin
      if (att_n < 64) begin
        att_adr[att_n] = wb_adr_o;
        att_we[att_n]  = wb_we_o;
      end
      att_n++;
      if (att_n == rty_at) begin
        wb_rty_i = 1'b1;
      end else if (wb_we_o && wb_adr_o == err_adr) begin
        wb_err_i = 1'b1;
      end else begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          if (wr_n < 64) begin
            wr_adr[wr_n] = wb_adr_o;
            wr_dat[wr_n] = wb_dat_o;
          end
          wr_n++;
        end else begin
          wb_dat_i = ((wb_adr_o - RD_BASE) >> 2) * 32'h11 + 32'h11;
        end
      end
    end
  end

  task automatic clear_log();
    att_n = 0; wr_n = 0; done_n = 0; busy_n = 0; stb_n = 0;
  endtask

  // Pulses start and waits (bounded) for done; lat is the cycle index of the done pulse.
  task automatic do_run(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                        output int lat);
    clear_log();
    src_base = s; dst_base = d; count = n; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    err_done = error; cyc_done = wb_cyc_o; busy_done = busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_cyc_stb_we got=%b exp=000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got=%h exp=0", wb_adr_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
    checks++; if (wb_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel got=%h exp=f", wb_sel_o); end
  endtask

  task automatic test_copy();
    int lat;
    do_run(RD_BASE, WR_BASE, 8'd4, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL copy_latency got=%0d exp=16", lat); end
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL copy_writes got=%0d exp=4", wr_n); end
    checks++; if (att_n !== 8) begin errors++; $display("FAIL copy_accesses got=%0d exp=8", att_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (att_adr[2*i] !== RD_BASE + 32'(4*i) || att_we[2*i] !== 1'b0) begin errors++; $display("FAIL copy_rd_adr[%0d] got=%h exp=%h", i, att_adr[2*i], RD_BASE + 32'(4*i)); end
      checks++; if (wr_adr[i] !== WR_BASE + 32'(4*i)) begin errors++; $display("FAIL copy_wr_adr[%0d] got=%h exp=%h", i, wr_adr[i], WR_BASE + 32'(4*i)); end
      checks++; if (wr_dat[i] !== 32'(17*(i+1))) begin errors++; $display("FAIL copy_wr_dat[%0d] got=%h exp=%h", i, wr_dat[i], 32'(17*(i+1))); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL copy_done_pulses got=%0d exp=1", done_n); end
    checks++; if (busy_n !== 15) begin errors++; $display("FAIL copy_busy_cycles got=%0d exp=15", busy_n); end
    checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL copy_error got=%b exp=0", err_done); end
    checks++; if (cyc_done !== 1'b0 || busy_done !== 1'b0) begin errors++; $display("FAIL copy_fin_cyc_busy got=%b%b exp=00", cyc_done, busy_done); end
  endtask

  task automatic test_count_zero();
    int lat;
    do_run(RD_BASE, WR_BASE, 8'd0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (stb_n !== 0) begin errors++; $display("FAIL zero_stb_cycles got=%0d exp=0", stb_n); end
    checks++; if (busy_n !== 0) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=0", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", done_n); end
  endtask

  task automatic test_retry();
    int lat;
    rty_at = 3;
    do_run(RD_BASE, WR_BASE, 8'd4, lat);
    rty_at = 0;
    checks++; if (att_n !== 9) begin errors++; $display("FAIL retry_accesses got=%0d exp=9", att_n); end
    checks++; if (att_adr[2] !== 32'h9900_0004 || att_adr[3] !== 32'h9900_0004) begin errors++; $display("FAIL retry_reissue got=%h,%h exp=99000004", att_adr[2], att_adr[3]); end
    checks++; if (wr_n !== 4 || wr_dat[1] !== 32'h22 || wr_dat[3] !== 32'h44) begin errors++; $display("FAIL retry_writes got n=%0d d1=%h d3=%h exp 4,22,44", wr_n, wr_dat[1], wr_dat[3]); end
    checks++; if (lat !== 18) begin errors++; $display("FAIL retry_latency got=%0d exp=18", lat); end
    checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL retry_error got=%b exp=0", err_done); end
  endtask

  task automatic test_error();
    int lat;
    err_adr = 32'h0000_1008;
    do_run(RD_BASE, WR_BASE, 8'd4, lat);
    err_adr = 32'hFFFF_FFFC;
    checks++; if (lat !== 12) begin errors++; $display("FAIL err_latency got=%0d exp=12", lat); end
    checks++; if (err_done !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL err_flag got=%b/%b exp=1", err_done, error); end
    checks++; if (wr_n !== 2 || wr_adr[0] !== 32'h1000 || wr_adr[1] !== 32'h1004) begin errors++; $display("FAIL err_writes got n=%0d a0=%h a1=%h exp 2,1000,1004", wr_n, wr_adr[0], wr_adr[1]); end
    checks++; if (att_n !== 6 || att_adr[5] !== 32'h1008) begin errors++; $display("FAIL err_no_100c got n=%0d last=%h exp 6,1008", att_n, att_adr[5]); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL err_done_pulses got=%0d exp=1", done_n); end
    do_run(RD_BASE, WR_BASE, 8'd0, lat);
    checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", err_done); end
  endtask

  task automatic test_start_ignored();
    int lat;
    clear_log();
    src_base = RD_BASE; dst_base = WR_BASE; count = 8'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5) begin
        src_base = 32'hDEAD_0000; count = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (lat !== 12) begin errors++; $display("FAIL busy_start_latency got=%0d exp=12", lat); end
    checks++; if (wr_n !== 3) begin errors++; $display("FAIL busy_start_writes got=%0d exp=3", wr_n); end
    checks++; if (att_adr[4] !== 32'h9900_0008) begin errors++; $display("FAIL busy_start_src got=%h exp=99000008", att_adr[4]); end
  endtask

  task automatic test_reset_midrun();
    clear_log();
    src_base = RD_BASE; dst_base = WR_BASE; count = 8'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL midrun_active got=%b exp=1", wb_cyc_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, busy, done} !== 4'b0000) begin errors++; $display("FAIL midrun_async_drop got=%b exp=0000", {wb_cyc_o, wb_stb_o, busy, done}); end
    checks++; if (wb_adr_o !== 32'h0 || wb_we_o !== 1'b0) begin errors++; $display("FAIL midrun_adr_we got=%h/%b exp=0/0", wb_adr_o, wb_we_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (done_n !== 0) begin errors++; $display("FAIL midrun_no_done got=%0d exp=0", done_n); end
    checks++; if ({wb_cyc_o, busy, error} !== 3'b000) begin errors++; $display("FAIL midrun_idle got=%b exp=000", {wb_cyc_o, busy, error}); end
  endtask

`ifdef PERF_SNAP_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    mute = 1'b1;
    do_run(RD_BASE, WR_BASE, 8'd1, lat);
    mute = 1'b0;
    checks++; if (stb_n !== 16) begin errors++; $display("FAIL timeout_stb_cycles got=%0d exp=16", stb_n); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL timeout_latency got=%0d exp=17", lat); end
    checks++; if (err_done !== 1'b1) begin errors++; $display("FAIL timeout_error got=%b exp=1", err_done); end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_copy();
    test_count_zero();
    test_retry();
    test_error();
    test_start_ignored();
    test_reset_midrun();
`ifdef PERF_SNAP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/perf_snap_master.md
Name: perf_snap_master

Overview:
- Wishbone initiator that copies a block of 32-bit words from a source region to a destination region, one word at a time.
- Typical use: snapshot the performance-counter bank at 0x9900_0000 into SRAM without CPU involvement.
- Sits on a spare master port of the system Wishbone arbiter. Controlled by a simple start/busy/done sideband from a local control register block.

Parameters:
- CNT_W, 8, width of the word-count input and internal index (max 255 words per run).
- TIMEOUT_CYCLES, 256, cycles without ack/err/rty before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- src_base  in  32  word-aligned source byte address
- dst_base  in  32  word-aligned destination byte address
- count  in  CNT_W  number of words to copy
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse at end of run (success or abort)
- error  out  1  sticky; set on abort, cleared by the next accepted start
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  address
- wb_sel_o  out  4  byte selects, always 4'hF
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- wb_rty_i  in  1  retry

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; cyc/stb/we/busy/done/error=0; adr/dat_o=0; index=0; data latch=0.
- Start acceptance:
  - start is sampled only in IDLE. start while busy is ignored.
  - src_base, dst_base and count are latched on the accepted start.
  - count=0: go straight to FIN. done pulses 1 cycle after start; no bus activity.
- FSM states:
  - IDLE -> RD (start, count!=0).
  - RD: cyc=1, stb=1, we=0, adr=src+4*idx. On ack: latch wb_dat_i -> RGAP.
  - RGAP: cyc=1, stb=0 for one cycle -> WR.
  - WR: cyc=1, stb=1, we=1, adr=dst+4*idx, dat_o=latched word. On ack: idx++ -> if idx+1==count then FIN, else WGAP.
  - WGAP: cyc=1, stb=0 for one cycle -> RD.
  - FIN: cyc=0, stb=0, done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Bus rules:
  - cyc stays high for the entire run.
  - stb never stays high past the cycle in which ack/err/rty is sampled.
  - Outputs are registered; adr/we/dat_o are stable while stb=1.
  - Minimum per-word cost: 2 gap cycles plus 2 acked accesses.
- Priority when several responses are high in one cycle: err > rty > ack.
- Retry: rty in RD/WR deasserts stb for one cycle, then re-issues the same access with idx unchanged. Unlimited retries.
- Error: err in RD/WR -> FIN with error=1. Partial words already written stay written.
- Address arithmetic: 32-bit wrap-around; no carry detection. adr[1:0] is always 0.
- rst_n asserted mid-run: all state cleared immediately, cyc/stb drop asynchronously, no done pulse.

Optional Feature:
- Macro: PERF_SNAP_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles with stb=1 and none of ack/err/rty.
  - Reaching TIMEOUT_CYCLES is treated exactly as err: abort to FIN, error=1.
  - The counter clears on every response and at each new access.
- Undefined: no watchdog logic; the master waits indefinitely for a response.

Test Plan:
- src=0x9900_0000, dst=0x0000_1000, count=4, slave acks in 1 cycle with data 0x11,0x22,0x33,0x44 -> writes to 0x1000/04/08/0C carry 0x11..0x44. done pulses once, error=0, busy high throughout, cyc low after FIN.
- count=0 with start -> no stb ever asserted; done pulses in the cycle after start; busy never asserted for more than that cycle.
- Slave asserts rty on the 2nd read once, then acks -> address 0x9900_0004 issued twice; 4 reads and 4 writes complete; error=0.
- Slave asserts err on the write to 0x1008 -> done pulses and error=1; 0x1000 and 0x1004 written; no access to 0x100C; next start clears error.
- start pulsed during a run; rst_n pulsed low mid-run -> the in-run start is ignored (no change to latched count). The reset drops cyc/stb in the same cycle, all outputs return to 0, and no done pulse is produced.
- With PERF_SNAP_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never responds -> stb high exactly 16 cycles, then done=1 and error=1.
